lsu_mem_stage: RTL and testbench
================================

// Module: lsu_mem_stage
// PURPOSE
//  Memory-access stage directly downstream of the LSQ. Accepts one load or committed
//  store per handshake from the LSQ execute port, forms the aligned data-cache request
//  (byte enables, shifted store data), waits out cache latency, then sign/zero-extends
//  load data and holds a writeback to the CDB until it is granted.
//  Its busy status drives the LSQ's cache_stall input; req_rdy drives the LSQ's alu_rdy.
// PARAMETERS
//  XLEN       32                   data/address width
//  TAG_WIDTH  uarch_pkg::TAG_WIDTH  ROB tag width
// PORTS
//  clk             in   1          clock
//  rst             in   1          synchronous, active-high reset
//  flush           in   1          pipeline flush (kills un-returned loads only)
//  req_valid       in   1          LSQ presents a memory op
//  req_rdy         out  1          stage idle, can accept (to LSQ alu_rdy)
//  req_is_store    in   1          1=store, 0=load
//  req_funct3      in   3          RV32 funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  req_addr        in   XLEN       effective address from AGU
//  req_wdata       in   XLEN       store data (rs2), low bytes significant
//  req_tag         in   TAG_WIDTH  ROB tag of the op
//  dmem_req_valid  out  1          cache request valid
//  dmem_req_rdy    in   1          cache accepts request
//  dmem_req_we     out  1          write request
//  dmem_req_addr   out  XLEN       word-aligned address ({addr[XLEN-1:2],2'b00})
//  dmem_req_be     out  4          byte enables
//  dmem_req_wdata  out  XLEN       lane-shifted store data
//  dmem_resp_valid in   1          load data returned (loads only)
//  dmem_resp_rdata in   XLEN       returned word
//  cache_stall     out  1          stage busy (state != IDLE), to LSQ
//  wb_valid        out  1          load writeback valid
//  wb_rdy          in   1          CDB grant
//  wb_tag          out  TAG_WIDTH  ROB tag of writeback
//  wb_data         out  XLEN       extended load data
//  wb_exc          out  1          load misaligned exception flag
//  st_misalign     out  1          one-cycle pulse: misaligned store dropped
// BEHAVIOUR
//  Reset: state=IDLE; all valid/pulse outputs 0; wb_tag/wb_data/dmem_req_* = 0.
//  FSM: IDLE, REQ, RESP, WB, DRAIN. req_rdy = (state==IDLE); cache_stall = !req_rdy.
//  IDLE: on req_valid && req_rdy, latch op fields; misalign check:
//  half needs addr[0]==0, word needs addr[1:0]==0.
//   aligned -> REQ. Misaligned load -> WB with wb_exc=1, wb_data=0.
//   Misaligned store -> st_misalign=1 next cycle, stay IDLE.
//  REQ: dmem_req_valid=1, all dmem_req_* stable until dmem_req_rdy.
//   On accept: store -> IDLE (no writeback; stores arrive already committed); load -> RESP.
//   flush while load in REQ -> IDLE, request withdrawn; flush never affects stores.
//  RESP: on dmem_resp_valid register extended data -> WB. flush -> DRAIN (or IDLE if
//   resp arrives the same cycle; data discarded).
//  DRAIN: wait dmem_resp_valid, discard, -> IDLE. No writeback.
//  WB: wb_valid=1, tag/data/exc held until wb_rdy; then -> IDLE. flush in WB -> IDLE, no wb.
//  Byte enables: SB 4'b0001<<a[1:0]; SH 4'b0011<<a[1:0]; SW 4'b1111.
//  Store data: wdata[7:0] or [15:0] replicated to all lanes; SW unchanged.
//  Load extract: byte = rdata>>(8*a[1:0]), half = rdata>>(8*a[1:0]);
//   LB/LH sign-extend; LBU/LHU zero-extend to XLEN; LW passthrough.
//  Undefined funct3 (011,110,111): treated as word op.
//  Latency (aligned load, zero-wait cache): accept N, dmem_req_valid N+1,
//   resp N+2, wb_valid N+3. Store occupies stage until its request is accepted.
//  Only one op in flight; no new accept until back in IDLE (throughput <=1 per 2 cycles).
//  rst mid-operation: immediate return to IDLE, outputs to reset values;
//   in-flight response after reset ignored.
// TESTING
//  LB addr 0x103, resp 0x80FF_FF00 -> be n/a, wb_data=0xFFFF_FF80, wb_tag matches, wb at N+3.
//  SH addr 0x202 wdata 0x1234_ABCD -> dmem_req_be=4'b1100, wdata=0xABCD_ABCD,
//   addr=0x200, no wb_valid.
//  LW addr 0x101 -> no dmem_req_valid; wb_valid with wb_exc=1, wb_data=0;
//   SW addr 0x102 -> st_misalign pulse.
//  dmem_req_rdy low 3 cycles then high -> req fields stable throughout,
//   req_rdy/cache_stall held; LHU 0xFFFF -> 0x0000_FFFF.
//  Load in RESP + flush, resp 2 cycles later -> DRAIN, no wb_valid, req_rdy high after resp.
//  wb_rdy low 4 cycles -> wb_valid/data/tag stable; store committed then flush in REQ
//   -> store still issued.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// Memory-access stage behind the LSQ. It forms the aligned data-cache request,
// waits for the cache, then extends load data and holds it for the CDB.
package uarch_pkg;
  localparam int TAG_WIDTH = 6;
endpackage

module lsu_mem_stage #(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = uarch_pkg::TAG_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 req_valid,
  output logic                 req_rdy,
  input  logic                 req_is_store,
  input  logic [2:0]           req_funct3,
  input  logic [XLEN-1:0]      req_addr,
  input  logic [XLEN-1:0]      req_wdata,
  input  logic [TAG_WIDTH-1:0] req_tag,
  output logic                 dmem_req_valid,
  input  logic                 dmem_req_rdy,
  output logic                 dmem_req_we,
  output logic [XLEN-1:0]      dmem_req_addr,
  output logic [3:0]           dmem_req_be,
  output logic [XLEN-1:0]      dmem_req_wdata,
  input  logic                 dmem_resp_valid,
  input  logic [XLEN-1:0]      dmem_resp_rdata,
  output logic                 cache_stall,
  output logic                 wb_valid,
  input  logic                 wb_rdy,
  output logic [TAG_WIDTH-1:0] wb_tag,
  output logic [XLEN-1:0]      wb_data,
  output logic                 wb_exc,
  output logic                 st_misalign
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_RESP  = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0] state;
  logic       op_store;
  logic [2:0] op_funct3;
  logic [1:0] op_lane;

  // Access size from funct3[1:0]: 00 byte, 01 half, anything else is a word.
  logic            req_is_byte, req_is_half, req_misalign;
  logic [3:0]      req_be;
  logic [XLEN-1:0] req_wdata_lanes;
  logic [XLEN-1:0] resp_shifted, load_ext;

  always_comb begin
    req_is_byte     = (req_funct3[1:0] == 2'b00);
    req_is_half     = (req_funct3[1:0] == 2'b01);
    req_misalign    = 1'b0;
    req_be          = 4'b1111;
    req_wdata_lanes = req_wdata;
    if (req_is_byte) begin
      req_be          = 4'b0001 << req_addr[1:0];
      req_wdata_lanes = {(XLEN/8){req_wdata[7:0]}};
    end else if (req_is_half) begin
      req_misalign    = req_addr[0];
      req_be          = 4'b0011 << req_addr[1:0];
      req_wdata_lanes = {(XLEN/16){req_wdata[15:0]}};
    end else begin
      req_misalign    = (req_addr[1:0] != 2'b00);
    end
  end

  always_comb begin
    resp_shifted = dmem_resp_rdata >> {op_lane, 3'b000};
    load_ext     = dmem_resp_rdata;
    case (op_funct3)
      3'b000:  load_ext = {{(XLEN-8){resp_shifted[7]}}, resp_shifted[7:0]};
      3'b001:  load_ext = {{(XLEN-16){resp_shifted[15]}}, resp_shifted[15:0]};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, resp_shifted[7:0]};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, resp_shifted[15:0]};
      default: load_ext = dmem_resp_rdata;
    endcase
  end

  assign req_rdy        = (state == S_IDLE);
  assign cache_stall    = !req_rdy;
  assign dmem_req_valid = (state == S_REQ);
  assign wb_valid       = (state == S_WB);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order inside the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      op_store       <= 1'b0;
      op_funct3      <= 3'b000;
      op_lane        <= 2'b00;
      dmem_req_we    <= 1'b0;
      dmem_req_addr  <= '0;
      dmem_req_be    <= 4'b0000;
      dmem_req_wdata <= '0;
      wb_tag         <= '0;
      wb_data        <= '0;
      wb_exc         <= 1'b0;
      st_misalign    <= 1'b0;
    end else begin
      st_misalign <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_store  <= req_is_store;
            op_funct3 <= req_funct3;
            op_lane   <= req_addr[1:0];
            wb_tag    <= req_tag;
            if (req_misalign) begin
              if (req_is_store) begin
                st_misalign <= 1'b1;
              end else begin
                wb_exc  <= 1'b1;
                wb_data <= '0;
                state   <= S_WB;
              end
            end else begin
              dmem_req_we    <= req_is_store;
              dmem_req_addr  <= {req_addr[XLEN-1:2], 2'b00};
              dmem_req_be    <= req_be;
              dmem_req_wdata <= req_wdata_lanes;
              wb_exc         <= 1'b0;
              state          <= S_REQ;
            end
          end
        end
        S_REQ: begin
          // Stores are already committed, so a flush must not withdraw them.
          if (op_store) begin
            if (dmem_req_rdy) state <= S_IDLE;
          end else if (flush) begin
            state <= S_IDLE;
          end else if (dmem_req_rdy) begin
            state <= S_RESP;
          end
        end
        S_RESP: begin
          if (flush) begin
            state <= dmem_resp_valid ? S_IDLE : S_DRAIN;
          end else if (dmem_resp_valid) begin
            wb_data <= load_ext;
            state   <= S_WB;
          end
        end
        S_DRAIN: begin
          if (dmem_resp_valid) state <= S_IDLE;
        end
        S_WB: begin
          if (flush || wb_rdy) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: loads, stores, misalignment, back-pressure,
// flush and reset behaviour, each checked with immediate assertions.
module tb_lsu_mem_stage;
  localparam int XLEN = 32;
  localparam int TW   = uarch_pkg::TAG_WIDTH;

  logic            clk = 1'b0;
  logic            rst, flush, req_valid, req_rdy, req_is_store;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr, req_wdata;
  logic [TW-1:0]   req_tag;
  logic            dmem_req_valid, dmem_req_rdy, dmem_req_we;
  logic [XLEN-1:0] dmem_req_addr, dmem_req_wdata;
  logic [3:0]      dmem_req_be;
  logic            dmem_resp_valid;
  logic [XLEN-1:0] dmem_resp_rdata;
  logic            cache_stall, wb_valid, wb_rdy, wb_exc, st_misalign;
  logic [TW-1:0]   wb_tag;
  logic [XLEN-1:0] wb_data;

  int checks   = 0;
  int failures = 0;

  lsu_mem_stage #(.XLEN(XLEN), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_rdy(req_rdy), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_tag(req_tag),
    .dmem_req_valid(dmem_req_valid), .dmem_req_rdy(dmem_req_rdy),
    .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
    .dmem_req_be(dmem_req_be), .dmem_req_wdata(dmem_req_wdata),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
    .cache_stall(cache_stall), .wb_valid(wb_valid), .wb_rdy(wb_rdy),
    .wb_tag(wb_tag), .wb_data(wb_data), .wb_exc(wb_exc),
    .st_misalign(st_misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [TW-1:0] t);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
    req_addr = a; req_wdata = wd; req_tag = t;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_is_store = 1'b0;
    req_funct3 = 3'b000; req_addr = '0; req_wdata = '0; req_tag = '0;
    dmem_req_rdy = 1'b1; dmem_resp_valid = 1'b0; dmem_resp_rdata = '0; wb_rdy = 1'b0;
    step(); step();

    // Reset state
    check("rst_req_rdy", 32'(req_rdy), 32'd1);
    check("rst_stall", 32'(cache_stall), 32'd0);
    check("rst_dmem_valid", 32'(dmem_req_valid), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_st_misalign", 32'(st_misalign), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_wb_tag", 32'(wb_tag), 32'd0);
    check("rst_dmem_addr", dmem_req_addr, 32'd0);
    check("rst_dmem_be", 32'(dmem_req_be), 32'd0);
    rst = 1'b0;

    // LB 0x103, response 0x80FF_FF00 -> lane 3 byte 0x80 sign-extended
    issue(1'b0, 3'b000, 32'h103, 32'h0, 6'd5);
    step(); // N+1
    req_valid = 1'b0;
    check("lb_req_valid", 32'(dmem_req_valid), 32'd1);
    check("lb_req_we", 32'(dmem_req_we), 32'd0);
    check("lb_req_addr", dmem_req_addr, 32'h100);
    check("lb_req_rdy", 32'(req_rdy), 32'd0);
    step(); // N+2
    check("lb_resp_no_wb", 32'(wb_valid), 32'd0);
    check("lb_resp_req_drop", 32'(dmem_req_valid), 32'd0);
    dmem_resp_valid = 1'b1; dmem_resp_rdata = 32'h80FF_FF00;
    step(); // N+3
    dmem_resp_valid = 1'b0;
    check("lb_wb_valid", 32'(wb_valid), 32'd1);
    check("lb_wb_data", wb_data, 32'hFFFF_FF80);
    check("lb_wb_tag", 32'(wb_tag), 32'd5);
    check("lb_wb_exc", 32'(wb_exc), 32'd0);
    wb_rdy = 1'b1;
    step();
    wb_rdy = 1'b0;
    check("lb_done_wb", 32'(wb_valid), 32'd0);
    check("lb_done_idle", 32'(req_rdy), 32'd1);

    // SH 0x202 wdata 0x1234_ABCD
    issue(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 6'd7);
    step();
    req_valid = 1'b0;
    check("sh_req_valid", 32'(dmem_req_valid), 32'd1);
    check("sh_req_we", 32'(dmem_req_we), 32'd1);
    check("sh_req_be", 32'(dmem_req_be), 32'b1100);
    check("sh_req_wdata", dmem_req_wdata, 32'hABCD_ABCD);
    check("sh_req_addr", dmem_req_addr, 32'h200);
    step();
    check("sh_idle", 32'(req_rdy), 32'd1);
    check("sh_no_wb", 32'(wb_valid), 32'd0);
    check("sh_req_gone", 32'(dmem_req_valid), 32'd0);

    // SB 0x001 wdata 0xAB -> lane 1, byte replicated
    issue(1'b1, 3'b000, 32'h001, 32'h0000_00AB, 6'd2);
    step();
    req_valid = 1'b0;
    check("sb_req_be", 32'(dmem_req_be), 32'b0010);
    check("sb_req_wdata", dmem_req_wdata, 32'hABAB_ABAB);
    step();

    // Misaligned LW 0x101 -> exception writeback, no cache request
    issue(1'b0, 3'b010, 32'h101, 32'h0, 6'd9);
    step();
    req_valid = 1'b0;
    check("lw_mis_no_req", 32'(dmem_req_valid), 32'd0);
    check("lw_mis_wb_valid", 32'(wb_valid), 32'd1);
    check("lw_mis_exc", 32'(wb_exc), 32'd1);
    check("lw_mis_data", wb_data, 32'd0);
    check("lw_mis_tag", 32'(wb_tag), 32'd9);
    wb_rdy = 1'b1;
    step();
    wb_rdy = 1'b0;
    check("lw_mis_done", 32'(wb_valid), 32'd0);

    // Misaligned SW 0x102 -> one-cycle st_misalign pulse, stays idle
    issue(1'b1, 3'b010, 32'h102, 32'h5555_5555, 6'd1);
    step();
    req_valid = 1'b0;
    check("sw_mis_pulse", 32'(st_misalign), 32'd1);
    check("sw_mis_idle", 32'(req_rdy), 32'd1);
    check("sw_mis_no_req", 32'(dmem_req_valid), 32'd0);
    step();
    check("sw_mis_pulse_end", 32'(st_misalign), 32'd0);

    // LHU 0x102 with cache back-pressure for 3 cycles, then CDB back-pressure for 4
    dmem_req_rdy = 1'b0;
    issue(1'b0, 3'b101, 32'h102, 32'h0, 6'd3);
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dmem_req_rdy = 1'b1;
      check("lhu_stall_valid", 32'(dmem_req_valid), 32'd1);
      check("lhu_stall_addr", dmem_req_addr, 32'h100);
      check("lhu_stall_be", 32'(dmem_req_be), 32'b1100);
      check("lhu_stall_busy", 32'(cache_stall), 32'd1);
      check("lhu_stall_rdy", 32'(req_rdy), 32'd0);
      step();
    end
    dmem_resp_valid = 1'b1; dmem_resp_rdata = 32'hFFFF_1234;
    step();
    dmem_resp_valid = 1'b0; dmem_resp_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      check("lhu_hold_valid", 32'(wb_valid), 32'd1);
      check("lhu_hold_data", wb_data, 32'h0000_FFFF);
      check("lhu_hold_tag", 32'(wb_tag), 32'd3);
      step();
    end
    wb_rdy = 1'b1;
    check("lhu_grant_valid", 32'(wb_valid), 32'd1);
    step();
    wb_rdy = 1'b0;
    check("lhu_done", 32'(req_rdy), 32'd1);

    // Load flushed in RESP; response two cycles later is drained
    issue(1'b0, 3'b000, 32'h100, 32'h0, 6'd4);
    step();
    req_valid = 1'b0;
    step(); // RESP
    flush = 1'b1;
    step(); // DRAIN
    flush = 1'b0;
    check("drain_no_wb", 32'(wb_valid), 32'd0);
    check("drain_busy", 32'(req_rdy), 32'd0);
    step();
    check("drain_wait", 32'(cache_stall), 32'd1);
    dmem_resp_valid = 1'b1; dmem_resp_rdata = 32'h1111_1111;
    step();
    dmem_resp_valid = 1'b0;
    check("drain_idle", 32'(req_rdy), 32'd1);
    check("drain_no_wb2", 32'(wb_valid), 32'd0);

    // Committed store survives flush in REQ
    dmem_req_rdy = 1'b0;
    issue(1'b1, 3'b010, 32'h300, 32'hDEAD_BEEF, 6'd1);
    step();
    req_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("st_flush_valid", 32'(dmem_req_valid), 32'd1);
    check("st_flush_we", 32'(dmem_req_we), 32'd1);
    check("st_flush_be", 32'(dmem_req_be), 32'b1111);
    check("st_flush_wdata", dmem_req_wdata, 32'hDEAD_BEEF);
    dmem_req_rdy = 1'b1;
    step();
    check("st_flush_done", 32'(req_rdy), 32'd1);

    // Load flushed in REQ is withdrawn
    dmem_req_rdy = 1'b0;
    issue(1'b0, 3'b010, 32'h400, 32'h0, 6'd6);
    step();
    req_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    dmem_req_rdy = 1'b1;
    check("ld_flush_req_gone", 32'(dmem_req_valid), 32'd0);
    check("ld_flush_idle", 32'(req_rdy), 32'd1);

    // Reset during RESP; late response ignored
    issue(1'b0, 3'b010, 32'h500, 32'h0, 6'd8);
    step();
    req_valid = 1'b0;
    step(); // RESP
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_idle", 32'(req_rdy), 32'd1);
    check("midrst_addr", dmem_req_addr, 32'd0);
    check("midrst_tag", 32'(wb_tag), 32'd0);
    dmem_resp_valid = 1'b1; dmem_resp_rdata = 32'h2222_2222;
    step();
    dmem_resp_valid = 1'b0;
    check("midrst_no_wb", 32'(wb_valid), 32'd0);
    check("midrst_still_idle", 32'(req_rdy), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
